synapse_unit: RTL and testbench

SYNAPSE_UNIT -- requirements
Module: synapse_unit

---
 rtl/synapse_unit_if.sv | 24 ++
 rtl/synapse_unit.sv | 80 ++++++++
 tb/tb_synapse_unit.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/synapse_unit_if.sv
// Handshake bundle between the fire dispatcher, the synapse memory and the
// downstream fire consumer. The unit itself uses the slave view.
interface synapse_unit_if;
  logic        syn_vld;
  logic [9:0]  syn_addr;
  logic        syn_rdy;
  logic        mem_rd_en;
  logic [9:0]  mem_rd_addr;
  logic [15:0] mem_rd_data;
  logic        fire_vld;
  logic [7:0]  fire_weight;
  logic [7:0]  fire_target;
  logic        fire_rdy;

  modport slave (
    input  syn_vld, syn_addr, mem_rd_data, fire_rdy,
    output syn_rdy, mem_rd_en, mem_rd_addr, fire_vld, fire_weight, fire_target
  );

  modport master (
    output syn_vld, syn_addr, mem_rd_data, fire_rdy,
    input  syn_rdy, mem_rd_en, mem_rd_addr, fire_vld, fire_weight, fire_target
  );
endinterface

// File: rtl/synapse_unit.sv
// Synapse fetch unit: accepts synapse indices, reads weight/target from the
// synapse memory and queues non-zero-weight fires in a credit-managed FIFO.
module synapse_unit #(
  parameter int FIFO_DEPTH = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          clear_count,
  output logic [15:0]   fire_count,
  output logic          idle,
  synapse_unit_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW:0]   DEPTH_V  = (CW + 1)'(FIFO_DEPTH);

  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          inflight;
  logic [CW:0]   used;
  logic          syn_rdy_int;
  logic          accept;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // A read in flight holds a credit so its data always has a free slot.
  assign used        = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign syn_rdy_int = reset && enable && (used < DEPTH_V);
  assign accept      = bus.syn_vld && syn_rdy_int;
  assign push        = inflight && (bus.mem_rd_data[15:8] != 8'd0);
  assign pop         = (count != '0) && bus.fire_rdy;

  assign bus.syn_rdy     = syn_rdy_int;
  assign bus.mem_rd_en   = accept;
  assign bus.mem_rd_addr = accept ? bus.syn_addr : 10'd0;
  assign bus.fire_vld    = (count != '0);
  assign bus.fire_weight = fifo_mem[rd_ptr][15:8];
  assign bus.fire_target = fifo_mem[rd_ptr][7:0];
  assign idle            = (count == '0) && !inflight;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      inflight   <= 1'b0;
      fire_count <= '0;
    end else begin
      inflight <= accept;
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (clear_count) begin
        fire_count <= '0;
      end else if (pop && (fire_count != 16'hFFFF)) begin
        fire_count <= fire_count + 16'd1;
      end
    end
  end

  // Payload storage needs no reset: count gates visibility of every slot.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.mem_rd_data;
  end

  no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && ({1'b0, count} == DEPTH_V)));
endmodule

// File: tb/tb_synapse_unit.sv
// Randomised scoreboard bench for synapse_unit with directed phases for the
// single fire, backpressure, zero weight, throughput, reset and saturation cases.
module tb_synapse_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        clear_count = 1'b0;
  logic [15:0] fire_count;
  logic        idle;

  synapse_unit_if bus();

  synapse_unit #(.FIFO_DEPTH(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .clear_count (clear_count),
    .fire_count  (fire_count),
    .idle        (idle),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [1024];
  logic [15:0] exp_q [$];
  logic [15:0] exp_fc = 16'd0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_accept = 0;
  int          n_fire = 0;
  logic        acc_nz = 1'b0;
  logic        acc_zero = 1'b0;
  logic        sb_acc;
  int          occ;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, output int cycles);
    int k = 0;
    while (!(idle && exp_q.size() == 0) && k < 300) begin
      tick();
      k++;
    end
    cycles = k;
    check({name, "_drain_bound"}, 32'(k < 300), 32'd1);
  endtask

  // Synchronous synapse memory: data valid one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    bus.mem_rd_data <= bus.mem_rd_en ? mem[bus.mem_rd_addr] : 16'($urandom);
  end

  // Stimulus-side scoreboard feeder: every accept queues its expected fire.
  always @(negedge clk) begin
    sb_acc = bus.syn_vld && bus.syn_rdy;
    check("mem_rd_en", 32'(bus.mem_rd_en), 32'(sb_acc));
    if (sb_acc) begin
      check("mem_rd_addr", 32'(bus.mem_rd_addr), 32'(bus.syn_addr));
      n_accept++;
      if (mem[bus.syn_addr][15:8] != 8'd0) exp_q.push_back(mem[bus.syn_addr]);
    end
    acc_nz   = sb_acc && (mem[bus.syn_addr][15:8] != 8'd0);
    acc_zero = sb_acc && (mem[bus.syn_addr][15:8] == 8'd0);
  end

  // Output monitor: compares presented fires and status against the model.
  always begin
    @(posedge clk);
    #2;
    if (!reset) begin
      check("rst_fire_vld", 32'(bus.fire_vld), 32'd0);
      check("rst_idle", 32'(idle), 32'd1);
      check("rst_fire_count", 32'(fire_count), 32'd0);
      check("rst_syn_rdy", 32'(bus.syn_rdy), 32'd0);
      exp_q.delete();
      exp_fc = 16'd0;
    end else begin
      occ = exp_q.size() + (acc_zero ? 1 : 0);
      check("syn_rdy", 32'(bus.syn_rdy), 32'(enable && occ < 3));
      check("idle", 32'(idle), 32'(occ == 0));
      check("fire_vld", 32'(bus.fire_vld), 32'((exp_q.size() - (acc_nz ? 1 : 0)) > 0));
      check("fire_count", 32'(fire_count), 32'(exp_fc));
      if (bus.fire_vld && exp_q.size() > 0) begin
        check("fire_weight", 32'(bus.fire_weight), 32'(exp_q[0][15:8]));
        check("fire_target", 32'(bus.fire_target), 32'(exp_q[0][7:0]));
        if (bus.fire_rdy) begin
          void'(exp_q.pop_front());
          n_fire++;
        end
      end
      if (clear_count) exp_fc = 16'd0;
      else if (bus.fire_vld && bus.fire_rdy && exp_fc != 16'hFFFF) exp_fc = exp_fc + 16'd1;
    end
  end

  initial begin
    int addr;
    int base;
    int cyc;
    logic rdy_now;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 16'($urandom);
      if (i < 512) mem[i][8] = 1'b1;
      else if ($urandom_range(3) == 0) mem[i][15:8] = 8'd0;
    end
    bus.syn_vld  = 1'b0;
    bus.syn_addr = 10'd0;
    bus.fire_rdy = 1'b0;
    repeat (3) tick();
    check("init_idle", 32'(idle), 32'd1);
    check("init_syn_rdy", 32'(bus.syn_rdy), 32'd0);
    check("init_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
    reset = 1'b1;
    enable = 1'b1;
    tick();

    // Single fire with fixed latency.
    mem[5] = 16'h0A17;
    bus.fire_rdy = 1'b1;
    bus.syn_vld = 1'b1;
    bus.syn_addr = 10'h005;
    tick();
    bus.syn_vld = 1'b0;
    check("single_vld_early", 32'(bus.fire_vld), 32'd0);
    tick();
    check("single_vld", 32'(bus.fire_vld), 32'd1);
    check("single_weight", 32'(bus.fire_weight), 32'h0A);
    check("single_target", 32'(bus.fire_target), 32'h17);
    drain("single", cyc);
    check("single_count", 32'(fire_count), 32'd1);
    check("single_idle", 32'(idle), 32'd1);

    // Backpressure: only three credits, then ordered release.
    bus.fire_rdy = 1'b0;
    base = n_accept;
    addr = 0;
    bus.syn_vld = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus.syn_addr = 10'(addr);
      rdy_now = bus.syn_rdy;
      tick();
      if (rdy_now) addr++;
    end
    check("bp_accepts", 32'(n_accept - base), 32'd3);
    check("bp_syn_rdy", 32'(bus.syn_rdy), 32'd0);
    base = n_fire;
    bus.fire_rdy = 1'b1;
    for (int c = 0; c < 100 && addr < 10; c++) begin
      bus.syn_addr = 10'(addr);
      rdy_now = bus.syn_rdy;
      tick();
      if (rdy_now) addr++;
    end
    bus.syn_vld = 1'b0;
    drain("bp", cyc);
    check("bp_fires", 32'(n_fire - base), 32'd10);

    // Zero-weight entry is dropped.
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    mem[100] = 16'h0511;
    mem[101] = 16'h0022;
    mem[102] = 16'hFB33;
    base = n_fire;
    bus.syn_vld = 1'b1;
    for (int c = 100; c < 103; c++) begin
      bus.syn_addr = 10'(c);
      tick();
    end
    bus.syn_vld = 1'b0;
    drain("zero", cyc);
    check("zero_fires", 32'(n_fire - base), 32'd2);
    check("zero_count", 32'(fire_count), 32'd2);

    // Throughput: 100 back-to-back accepts.
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    base = n_accept;
    bus.syn_vld = 1'b1;
    for (int c = 0; c < 100; c++) begin
      bus.syn_addr = 10'($urandom_range(511));
      check("tp_syn_rdy", 32'(bus.syn_rdy), 32'd1);
      tick();
    end
    bus.syn_vld = 1'b0;
    drain("tp", cyc);
    check("tp_tail_cycles", 32'(cyc <= 3), 32'd1);
    check("tp_accepts", 32'(n_accept - base), 32'd100);
    check("tp_count", 32'(fire_count), 32'd100);

    // Random traffic with enable, valid and backpressure toggling.
    for (int c = 0; c < 400; c++) begin
      bus.syn_vld  = 1'($urandom_range(1));
      bus.syn_addr = 10'($urandom_range(1023));
      bus.fire_rdy = ($urandom_range(3) != 0);
      enable       = ($urandom_range(4) != 0);
      tick();
    end
    // Draining continues with enable low.
    enable = 1'b0;
    bus.syn_vld = 1'b1;
    bus.fire_rdy = 1'b1;
    drain("en_off", cyc);
    bus.syn_vld = 1'b0;
    enable = 1'b1;

    // Reset mid-burst: two buffered, one in flight.
    bus.fire_rdy = 1'b0;
    bus.syn_vld = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.syn_addr = 10'(200 + c);
      tick();
    end
    bus.syn_vld = 1'b0;
    check("pre_rst_count", 32'(fire_count != 16'd0), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_fire_vld", 32'(bus.fire_vld), 32'd0);
    check("mid_rst_count", 32'(fire_count), 32'd0);
    check("mid_rst_idle", 32'(idle), 32'd1);
    repeat (2) tick();
    reset = 1'b1;
    bus.fire_rdy = 1'b1;
    base = n_fire;
    repeat (6) tick();
    check("post_rst_no_fire", 32'(n_fire - base), 32'd0);
    check("post_rst_idle", 32'(idle), 32'd1);

    // Saturation of fire_count, then clear against a concurrent pop.
    base = n_fire;
    bus.syn_vld = 1'b1;
    for (int c = 0; c < 70000 && (n_fire - base) < 65537; c++) begin
      bus.syn_addr = 10'($urandom_range(511));
      tick();
    end
    bus.syn_vld = 1'b0;
    drain("sat", cyc);
    check("sat_fires", 32'(n_fire - base >= 65537), 32'd1);
    check("sat_count", 32'(fire_count), 32'hFFFF);
    bus.fire_rdy = 1'b0;
    bus.syn_vld = 1'b1;
    bus.syn_addr = 10'd7;
    tick();
    bus.syn_vld = 1'b0;
    cyc = 0;
    while (!bus.fire_vld && cyc < 10) begin
      tick();
      cyc++;
    end
    check("clr_wait_bound", 32'(cyc < 10), 32'd1);
    bus.fire_rdy = 1'b1;
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    check("clr_count", 32'(fire_count), 32'd0);
    check("clr_idle", 32'(idle), 32'd1);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
